// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the E-stage datapath and the multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // E-stage side: issues operations and reads HI/LO for mfhi/mflo.
  modport master (
    output start, mdu_op, A, B,
    input  busy, hi_o, lo_o
  );

  // Unit side: accepts operations and presents the architectural HI/LO.
  modport slave (
    input  start, mdu_op, A, B,
    output busy, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// The full 64-bit result is computed at launch and parked in a shadow
// register; HI/LO only change when the fixed-latency countdown expires, so
// mfhi/mflo never observe a partial result.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mul_div_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state, state_next;
  op_e             op;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi, lo;
  logic [63:0]     shadow;
  logic            shadow_apply;

  logic            accept, is_mul, is_div, launch, done;
  logic [63:0]     result;
  logic            div_zero;

  assign op     = op_e'(bus.mdu_op);
  // A start seen while busy is dropped; the hazard unit retries it later.
  assign accept = bus.start && (state == S_IDLE);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign launch = accept && (is_mul || is_div);
  assign done   = (state == S_RUN) && (cnt == 1);

  // Combinational 64-bit result for whichever mult/div op is presented.
  always_comb begin
    logic [63:0] ext_a, ext_b;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    result   = '0;
    div_zero = 1'b0;
    // Low 64 bits of a 64x64 product of extended operands equal the 32x32 product.
    ext_a = (op == OP_MULT) ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
    ext_b = (op == OP_MULT) ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
    // Signed divide via magnitudes; 0x80000000 magnitude stays 0x80000000, so INT_MIN/-1 yields INT_MIN, rem 0.
    neg_a = (op == OP_DIV) && bus.A[31];
    neg_b = (op == OP_DIV) && bus.B[31];
    mag_a = neg_a ? -bus.A : bus.A;
    mag_b = neg_b ? -bus.B : bus.B;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;
    quo   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;
    if (is_mul) begin
      result = ext_a * ext_b;
    end else if (is_div) begin
      result   = {rem, quo};
      div_zero = (bus.B == 32'd0);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state: launch enters RUN, the last countdown edge returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (launch) state_next = S_RUN;
      S_RUN:  if (done)   state_next = S_IDLE;
      default:            state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state == S_RUN);
  end

  // Countdown, shadow capture and architectural HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow is reset along with HI/LO so a reset can never leak an aborted result later.
      hi           <= '0;
      lo           <= '0;
      shadow       <= '0;
      shadow_apply <= 1'b0;
      cnt          <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt - CW'(1);
      if (done && shadow_apply) begin
        hi <= shadow[63:32];
        lo <= shadow[31:0];
      end
    end else if (accept) begin
      if (launch) begin
        shadow       <= result;
        shadow_apply <= !div_zero;
        cnt          <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (op == OP_MTHI) begin
        hi <= bus.A;
      end else if (op == OP_MTLO) begin
        lo <= bus.A;
      end
    end
  end

  assign bus.hi_o = hi;
  assign bus.lo_o = lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected HI/LO and busy
// length into a scoreboard; a monitor pops and compares whenever busy falls.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                         OP_DIV  = 3'd3, OP_DIVU = 3'd4, OP_MTHI  = 3'd5,
                         OP_MTLO = 3'd6, OP_RSVD = 3'd7;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_done(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = OP_NONE;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      @(negedge clk);
    end
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  // Monitor: measures each busy window and scores HI/LO when it closes.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: busy window of %0d cycles, no expectation queued", run);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"},  64'(bus.hi_o), 64'(e.hi));
          check({e.name, "_lo"},  64'(bus.lo_o), 64'(e.lo));
          check({e.name, "_len"}, 64'(run),      64'(e.len));
        end
        run = 0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mdu_op = OP_NONE; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi",   64'(bus.hi_o), 64'd0);
    check("rst_lo",   64'(bus.lo_o), 64'd0);

    // MULT -2 * 3
    expect_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult");

    // MULTU max*max; old HI/LO must hold through the whole busy window
    expect_done("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      check("multu_busy",    64'(bus.busy), 64'd1);
      check("multu_hold_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
      check("multu_hold_lo", 64'(bus.lo_o), 64'hFFFF_FFFA);
      @(negedge clk);
    end
    wait_idle("multu");

    // DIV -7 / 2 with an MTLO attempted mid-flight (must be ignored)
    expect_done("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = OP_MTLO; bus.A = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = OP_NONE;
    check("mtlo_busy_lo", 64'(bus.lo_o), 64'h0000_0001);
    check("mtlo_busy_b",  64'(bus.busy), 64'd1);
    wait_idle("div");

    // DIVU by zero: full latency, HI/LO unchanged
    expect_done("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle("divu0");

    // MTHI / MTLO: single cycle, busy never rises
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi",   64'(bus.hi_o), 64'h1234_5678);
    check("mthi_lo",   64'(bus.lo_o), 64'hFFFF_FFFD);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    check("mtlo_lo",   64'(bus.lo_o), 64'hCAFE_F00D);
    check("mtlo_hi",   64'(bus.hi_o), 64'h1234_5678);
    check("mtlo_busy", 64'(bus.busy), 64'd0);

    // DIV corner cases and DIVU with remainder
    expect_done("div_min", 32'h0000_0000, 32'h8000_0000, 10);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_min");
    expect_done("divu", 32'h0000_000F, 32'h0FFF_FFFF, 10);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_idle("divu");
    expect_done("div_negb", 32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_negb");

    // NONE and reserved opcodes do nothing
    issue(OP_NONE, 32'h5555_5555, 32'd1);
    issue(OP_RSVD, 32'h5555_5555, 32'd1);
    check("nop_hi",   64'(bus.hi_o), 64'h0000_0001);
    check("nop_lo",   64'(bus.lo_o), 64'hFFFF_FFFD);
    check("nop_busy", 64'(bus.busy), 64'd0);

    // Back-to-back: start held across completion edge E is taken at E+1
    expect_done("b2b_1", 32'h0000_0000, 32'h0000_002A, 5);
    expect_done("b2b_2", 32'h0000_0001, 32'h0000_0000, 5);
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = OP_MULT; bus.A = 32'h0001_0000; bus.B = 32'h0001_0000;
    @(negedge clk);
    check("b2b_gap_busy", 64'(bus.busy), 64'd0);
    check("b2b_gap_lo",   64'(bus.lo_o), 64'h0000_002A);
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = OP_NONE;
    check("b2b_restart", 64'(bus.busy), 64'd1);
    wait_idle("b2b");

    // Reset in cycle 3 of a DIV aborts it; no late write afterwards
    expect_done("rst_abort", 32'h0000_0000, 32'h0000_0000, 3);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi",   64'(bus.hi_o), 64'd0);
    check("abort_lo",   64'(bus.lo_o), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (12) @(negedge clk);
    check("late_hi",   64'(bus.hi_o), 64'd0);
    check("late_lo",   64'(bus.lo_o), 64'd0);
    check("late_busy", 64'(bus.busy), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
